muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Iterative RV32M execution unit. It consumes the 5-bit ALU_CONTROL codes issued by ALU control for
//  MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU and returns the result through a START/BUSY/DONE handshake.
//  It sits in EX beside the single-cycle ALU. The pipeline stalls on BUSY.
// PARAMETERS
//  XLEN  32  operand/result width
// PORTS
//  CLK          in   1     clock, rising edge
//  RESET_N      in   1     asynchronous active-low reset
//  START        in   1     request valid
//  ALU_CONTROL  in   5     operation code (01010..10001 handled)
//  DATA1        in   XLEN  rs1 operand (multiplicand / dividend)
//  DATA2        in   XLEN  rs2 operand (multiplier / divisor)
//  FLUSH        in   1     abort the in-flight operation
//  RESULT       out  XLEN  result, valid when DONE; held until the next DONE
//  BUSY         out  1     operation in flight
//  DONE         out  1     single-cycle completion pulse
// BEHAVIOUR
//  - Clock/reset: one clock (CLK); RESET_N asynchronous active-low. Reset forces RESULT=0, BUSY=0, DONE=0, state IDLE,
//    and clears the counter and datapath registers. This also applies mid-operation; no DONE follows reset.
//  - FSM states: IDLE, CALC, FIX, DONE.
//  - Accept: START=1 && state in {IDLE,DONE} && code in 01010..10001.
//    - On acceptance, operands are latched as magnitudes plus sign flags, then CALC, count=XLEN-1.
//    - START with any other code, or while BUSY, is ignored.
//  - Sign handling:
//    - MUL, MULH, DIV, REM: both operands signed.
//    - MULHSU: DATA1 signed, DATA2 unsigned.
//    - MULHU, DIVU, REMU: unsigned.
//  - CALC: one iteration per cycle.
//    - Multiply: radix-2 shift-add into a 2*XLEN accumulator.
//    - Divide: restoring shift-subtract.
//    - When count==0, go to FIX; otherwise decrement count.
//  - FIX: apply sign correction and register RESULT, then go to DONE.
//    - MUL returns the low XLEN bits; MULH* return the high XLEN bits.
//    - Quotient sign = s1^s2. Remainder sign = s1.
//  - DONE: DONE=1 for one cycle, BUSY=0. Returns to IDLE unless a new request is accepted, which allows back-to-back issue.
//  - Latency: accept cycle = 0. CALC occupies cycles 1..XLEN, FIX is cycle XLEN+1, DONE is cycle XLEN+2. BUSY=1 in cycles 1..XLEN+1.
//  - Divisor==0 (resolved in FIX, latency unchanged):
//    - DIV/DIVU -> all ones.
//    - REM/REMU -> DATA1.
//  - Signed overflow, DIV with DATA1=0x80000000 and DATA2=-1: quotient 0x80000000, REM 0. Latency unchanged.
//  - FLUSH=1 in any state: go to IDLE on the next edge. DONE is suppressed and RESULT is not updated.
//    FLUSH together with START: FLUSH wins and the request is dropped.
//  - Operands are sampled only at acceptance. Input changes while BUSY have no effect.
// CONFIGURATION
//  MULDIV_FAST_MUL_EN
//  - Defined: the MUL family uses a single-cycle XLEN x XLEN product and bypasses CALC (IDLE -> FIX -> DONE).
//    DONE occurs in cycle 2 and BUSY=1 in cycle 1 only. Divide latency is unchanged.
//  - Undefined: every operation uses the iterative path with XLEN+2 latency.
// STRUCTURE
//  - Shared constants in alu_ctrl_pkg: ALU_CONTROL code localparams (ALU_MUL=5'b01010 .. ALU_REMU=5'b10001, ALU_INVALID=5'b11111).
//    The same codes are used by ALU control and this unit.
//  - FSM state encoding is local to this module.
//  - One sub-module, muldiv_step: combinational single iteration (add-shift or subtract-compare-shift), instantiated once.
// TESTING
//  1. MULHU 0xFFFFFFFF*0xFFFFFFFF -> RESULT 0xFFFFFFFE, DONE in cycle 34.
//     MUL 7*-3 -> 0xFFFFFFEB.
//  2. MULH 0x80000000*0x80000000 -> 0x40000000.
//     MULHSU 0xFFFFFFFF(-1)*0xFFFFFFFF -> 0xFFFFFFFF.
//  3. DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
//  4. DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5.
//     DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
//  5. FLUSH in cycle 10 -> no DONE, BUSY=0 at cycle 11, RESULT keeps its previous value.
//     RESET_N low mid-CALC -> all outputs 0 immediately.
//  6. Back-to-back START in the DONE cycle -> second DONE exactly 34 cycles later.
//     Invalid code 00010 with START -> no BUSY, no DONE.
//     With MULDIV_FAST_MUL_EN, MUL -> DONE in cycle 2.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared ALU_CONTROL codes and decode helpers for the RV32M multiply/divide unit.
// ALU control and muldiv_unit both use these codes.
package alu_ctrl_pkg;

  localparam logic [4:0] ALU_MUL     = 5'b01010;
  localparam logic [4:0] ALU_MULH    = 5'b01011;
  localparam logic [4:0] ALU_MULHSU  = 5'b01100;
  localparam logic [4:0] ALU_MULHU   = 5'b01101;
  localparam logic [4:0] ALU_DIV     = 5'b01110;
  localparam logic [4:0] ALU_DIVU    = 5'b01111;
  localparam logic [4:0] ALU_REM     = 5'b10000;
  localparam logic [4:0] ALU_REMU    = 5'b10001;
  localparam logic [4:0] ALU_INVALID = 5'b11111;

  // Per-operation control derived from the code at acceptance
  typedef struct packed {
    logic is_div;   // divide family (otherwise multiply)
    logic is_rem;   // remainder result (divide family only)
    logic high;     // upper half of the product (multiply family only)
    logic sign1;    // DATA1 interpreted as signed
    logic sign2;    // DATA2 interpreted as signed
  } md_op_t;

  function automatic logic is_muldiv(input logic [4:0] code);
    return (code >= ALU_MUL) && (code <= ALU_REMU);
  endfunction

  function automatic md_op_t decode_op(input logic [4:0] code);
    md_op_t op;
    op = '0;
    case (code)
      ALU_MUL:    begin op.sign1 = 1'b1; op.sign2 = 1'b1; end
      ALU_MULH:   begin op.high = 1'b1; op.sign1 = 1'b1; op.sign2 = 1'b1; end
      ALU_MULHSU: begin op.high = 1'b1; op.sign1 = 1'b1; end
      ALU_MULHU:  begin op.high = 1'b1; end
      ALU_DIV:    begin op.is_div = 1'b1; op.sign1 = 1'b1; op.sign2 = 1'b1; end
      ALU_DIVU:   begin op.is_div = 1'b1; end
      ALU_REM:    begin op.is_div = 1'b1; op.is_rem = 1'b1; op.sign1 = 1'b1; op.sign2 = 1'b1; end
      ALU_REMU:   begin op.is_div = 1'b1; op.is_rem = 1'b1; end
      default:    op = '0;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath on magnitudes.
// Multiply: acc = {high, multiplier}; conditionally add the multiplicand to the high half, shift right.
// Divide:   acc = {remainder, quotient}; shift left, trial-subtract the divisor, keep if no borrow.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic              is_div,
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   operand,
  output logic [2*XLEN-1:0] acc_next
);

  logic [XLEN:0] add_sum;
  logic [XLEN:0] top;
  logic [XLEN:0] diff;

  // Compute the next accumulator for either the add-shift or the subtract-compare-shift step
  always_comb begin
    add_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : {(XLEN+1){1'b0}});
    top     = acc[2*XLEN-1:XLEN-1];
    diff    = top - {1'b0, operand};
    if (is_div) begin
      if (!diff[XLEN]) acc_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else             acc_next = {acc[2*XLEN-2:0], 1'b0};
    end else begin
      acc_next = {add_sum, acc[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with a START/BUSY/DONE handshake.
// Optional macro MULDIV_FAST_MUL_EN: multiply family uses a single-cycle product and skips CALC.
module muldiv_unit
  import alu_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            START,
  input  logic [4:0]      ALU_CONTROL,
  input  logic [XLEN-1:0] DATA1,
  input  logic [XLEN-1:0] DATA2,
  input  logic            FLUSH,
  output logic [XLEN-1:0] RESULT,
  output logic            BUSY,
  output logic            DONE
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_FIX, ST_DONE} state_t;

  state_t            state, state_next;
  md_op_t            dec;
  logic              accept, fast_mul;
  logic              neg_a, neg_b;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [2*XLEN-1:0] acc, acc_next;
  logic [XLEN-1:0]   operand;
  logic [CW-1:0]     count;
  logic              is_div, is_rem, high, neg1, neg2;
  logic [2*XLEN-1:0] prod_mag, prod_res;
  logic [XLEN-1:0]   quo, rem, fix_result;

  // Decode the request and form operand magnitudes and sign flags
  always_comb begin
    dec    = decode_op(ALU_CONTROL);
    neg_a  = dec.sign1 & DATA1[XLEN-1];
    neg_b  = dec.sign2 & DATA2[XLEN-1];
    mag_a  = neg_a ? -DATA1 : DATA1;
    mag_b  = neg_b ? -DATA2 : DATA2;
    accept = START && !FLUSH && (state == ST_IDLE || state == ST_DONE) && is_muldiv(ALU_CONTROL);
`ifdef MULDIV_FAST_MUL_EN
    fast_mul = !dec.is_div;
`else
    fast_mul = 1'b0;
`endif
  end

  // State register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Next-state logic; FLUSH overrides everything
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (accept) state_next = fast_mul ? ST_FIX : ST_CALC;
        else        state_next = ST_IDLE;
      end
      ST_CALC: if (count == '0) state_next = ST_FIX;
      ST_FIX:  state_next = ST_DONE;
      default: state_next = ST_IDLE;
    endcase
    if (FLUSH) state_next = ST_IDLE;
  end

  // Handshake outputs decoded from state
  always_comb begin
    BUSY = (state == ST_CALC) || (state == ST_FIX);
    DONE = (state == ST_DONE);
  end

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div   (is_div),
    .acc      (acc),
    .operand  (operand),
    .acc_next (acc_next)
  );

  // Sign correction and half selection applied in FIX
  always_comb begin
`ifdef MULDIV_FAST_MUL_EN
    prod_mag = {{XLEN{1'b0}}, operand} * {{XLEN{1'b0}}, acc[XLEN-1:0]};
`else
    prod_mag = acc;
`endif
    prod_res = (neg1 ^ neg2) ? -prod_mag : prod_mag;
    quo      = acc[XLEN-1:0];
    rem      = acc[2*XLEN-1:XLEN];
    if (!is_div)             fix_result = high ? prod_res[2*XLEN-1:XLEN] : prod_res[XLEN-1:0];
    else if (is_rem)         fix_result = neg1 ? -rem : rem;
    else if (operand == '0)  fix_result = '1;
    else                     fix_result = (neg1 ^ neg2) ? -quo : quo;
  end

  // Operand capture at acceptance, iteration in CALC, result register in FIX
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      acc     <= '0;
      operand <= '0;
      count   <= '0;
      is_div  <= 1'b0;
      is_rem  <= 1'b0;
      high    <= 1'b0;
      neg1    <= 1'b0;
      neg2    <= 1'b0;
      RESULT  <= '0;
    end else begin
      if (accept) begin
        is_div <= dec.is_div;
        is_rem <= dec.is_rem;
        high   <= dec.high;
        neg1   <= neg_a;
        neg2   <= neg_b;
        count  <= CW'(XLEN-1);
        if (dec.is_div) begin
          acc     <= {{XLEN{1'b0}}, mag_a};
          operand <= mag_b;
        end else begin
          acc     <= {{XLEN{1'b0}}, mag_b};
          operand <= mag_a;
        end
      end else if (state == ST_CALC) begin
        acc <= acc_next;
        if (count != '0) count <= count - CW'(1);
      end
      if (state == ST_FIX && !FLUSH) RESULT <= fix_result;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases, flush/reset aborts,
// back-to-back issue and ignored requests. Honors MULDIV_FAST_MUL_EN for multiply latency.
module tb_muldiv_unit;
  import alu_ctrl_pkg::*;

  localparam int XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = XLEN + 2;
`endif
  localparam int DIV_LAT = XLEN + 2;

  logic            CLK = 1'b0;
  logic            RESET_N;
  logic            START;
  logic [4:0]      ALU_CONTROL;
  logic [XLEN-1:0] DATA1, DATA2;
  logic            FLUSH;
  logic [XLEN-1:0] RESULT;
  logic            BUSY, DONE;

  int              n_checks = 0;
  int              n_fail   = 0;
  logic [XLEN-1:0] exp_q[$];
  logic [XLEN-1:0] last_result = '0;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .START       (START),
    .ALU_CONTROL (ALU_CONTROL),
    .DATA1       (DATA1),
    .DATA2       (DATA2),
    .FLUSH       (FLUSH),
    .RESULT      (RESULT),
    .BUSY        (BUSY),
    .DONE        (DONE)
  );

  // 10-unit clock
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Drive one request for a single cycle, then scramble operands to show they are not resampled
  task automatic applyStimulus(input logic [4:0] code, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    ALU_CONTROL = code;
    DATA1       = a;
    DATA2       = b;
    START       = 1'b1;
    step();
    START       = 1'b0;
    ALU_CONTROL = ALU_INVALID;
    DATA1       = $urandom;
    DATA2       = $urandom;
  endtask

  task automatic issue(input logic [4:0] code, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [XLEN-1:0] exp);
    exp_q.push_back(exp);
    applyStimulus(code, a, b);
  endtask

  // Wait (bounded) for DONE, check latency and the scoreboard head; returns in the DONE cycle
  task automatic checkOutput(input string tag, input int exp_lat, input int start_cyc);
    int              cyc;
    logic [XLEN-1:0] exp;
    cyc = start_cyc;
    while (!DONE && cyc < 100) begin
      step();
      cyc++;
    end
    check({tag, " latency"}, XLEN'(cyc), XLEN'(exp_lat));
    if (exp_q.size() == 0) exp = 'x;
    else                   exp = exp_q.pop_front();
    check({tag, " result"}, RESULT, exp);
    last_result = exp;
  endtask

  // DONE must be a single pulse and RESULT must hold afterwards
  task automatic checkRelease(input string tag);
    step();
    check({tag, " done pulse"}, XLEN'(DONE), XLEN'(0));
    check({tag, " held"}, RESULT, last_result);
  endtask

  task automatic runOp(input string tag, input logic [4:0] code, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp, input int lat);
    issue(code, a, b, exp);
    check({tag, " busy"}, XLEN'(BUSY), XLEN'(1));
    checkOutput(tag, lat, 1);
    checkRelease(tag);
  endtask

  initial begin
    logic [XLEN-1:0] a, b;
    logic [63:0]     p;
    int              seen_done, seen_busy;

    RESET_N = 1'b0; START = 1'b0; FLUSH = 1'b0;
    ALU_CONTROL = ALU_INVALID; DATA1 = '0; DATA2 = '0;
    #12;
    check("reset RESULT", RESULT, '0);
    check("reset BUSY", XLEN'(BUSY), XLEN'(0));
    check("reset DONE", XLEN'(DONE), XLEN'(0));
    step();
    RESET_N = 1'b1;
    step();

    runOp("MULHU max",   ALU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT);
    runOp("MUL 7*-3",    ALU_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT);
    runOp("MULH min",    ALU_MULH,   32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT);
    runOp("MULHSU",      ALU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT);
    runOp("DIV -7/2",    ALU_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, DIV_LAT);
    runOp("REM -7/2",    ALU_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, DIV_LAT);
    runOp("DIVU 100/7",  ALU_DIVU,   32'd100,      32'd7,        32'd14,       DIV_LAT);
    runOp("REMU 100/7",  ALU_REMU,   32'd100,      32'd7,        32'd2,        DIV_LAT);
    runOp("DIV 100/-7",  ALU_DIV,    32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, DIV_LAT);
    runOp("DIVU 5/0",    ALU_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, DIV_LAT);
    runOp("REM 5/0",     ALU_REM,    32'd5,        32'd0,        32'd5,        DIV_LAT);
    runOp("REM -5/0",    ALU_REM,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, DIV_LAT);
    runOp("DIV ovf",     ALU_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, DIV_LAT);
    runOp("REM ovf",     ALU_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        DIV_LAT);

    // Randomized operands checked against a behavioural reference model
    for (int i = 0; i < 3; i++) begin
      a = $urandom;
      b = $urandom;
      p = 64'(a) * 64'(b);
      runOp("MULHU rnd", ALU_MULHU, a, b, p[63:32], MUL_LAT);
      runOp("MUL rnd",   ALU_MUL,   a, b, p[31:0],  MUL_LAT);
      b = XLEN'($urandom_range(1, 1000));
      runOp("DIVU rnd",  ALU_DIVU,  a, b, a / b,    DIV_LAT);
      if (i == 1) b = -b;
      runOp("REM rnd",   ALU_REM,   a, b, XLEN'($signed(a) % $signed(b)), DIV_LAT);
    end

    // FLUSH in cycle 10 aborts the operation
    applyStimulus(ALU_DIVU, 32'd1000, 32'd3);
    repeat (9) step();
    FLUSH = 1'b1;
    step();
    FLUSH = 1'b0;
    check("flush BUSY", XLEN'(BUSY), XLEN'(0));
    check("flush DONE", XLEN'(DONE), XLEN'(0));
    check("flush RESULT", RESULT, last_result);
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (DONE) seen_done++;
    end
    check("flush no DONE", XLEN'(seen_done), XLEN'(0));

    // FLUSH together with START drops the request
    FLUSH = 1'b1;
    applyStimulus(ALU_MUL, 32'd3, 32'd3);
    FLUSH = 1'b0;
    check("flush+start BUSY", XLEN'(BUSY), XLEN'(0));

    // START while busy is ignored
    issue(ALU_DIVU, 32'd100, 32'd7, 32'd14);
    repeat (4) step();
    ALU_CONTROL = ALU_MUL; DATA1 = 32'd9; DATA2 = 32'd9; START = 1'b1;
    step();
    START = 1'b0;
    checkOutput("start while busy", DIV_LAT, 6);
    checkRelease("start while busy");

    // Back-to-back: second request accepted in the DONE cycle
    issue(ALU_DIVU, 32'd200, 32'd7, 32'd28);
    checkOutput("b2b first", DIV_LAT, 1);
    issue(ALU_REMU, 32'd200, 32'd7, 32'd4);
    check("b2b done drop", XLEN'(DONE), XLEN'(0));
    checkOutput("b2b second", DIV_LAT, 1);
    checkRelease("b2b second");

    // Invalid code: no BUSY, no DONE
    applyStimulus(5'b00010, 32'd5, 32'd6);
    seen_done = 0;
    seen_busy = 0;
    for (int i = 0; i < 40; i++) begin
      if (DONE) seen_done++;
      if (BUSY) seen_busy++;
      step();
    end
    check("invalid no BUSY", XLEN'(seen_busy), XLEN'(0));
    check("invalid no DONE", XLEN'(seen_done), XLEN'(0));
    check("invalid RESULT", RESULT, last_result);

    // Reset mid-CALC clears outputs immediately and yields no DONE
    applyStimulus(ALU_MULHU, 32'hFFFFFFFF, 32'h12345678);
    repeat (4) step();
    RESET_N = 1'b0;
    #1;
    check("midreset RESULT", RESULT, '0);
    check("midreset BUSY", XLEN'(BUSY), XLEN'(0));
    check("midreset DONE", XLEN'(DONE), XLEN'(0));
    last_result = '0;
    step();
    RESET_N = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (DONE) seen_done++;
    end
    check("midreset no DONE", XLEN'(seen_done), XLEN'(0));

    runOp("after reset", ALU_DIV, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, DIV_LAT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
